imem_fetch_responder: RTL

- Multi-cycle instruction-memory responder: the memory end of the instruction-fetch interface.
- Accepts fetch requests (byte address) from the IF stage through a valid/ready handshake.
- Returns the 32-bit instruction after a fixed, parameterised latency, and supports abort on branch/jump redirect.
- Holds a byte-addressed program store filled through a byte-wide loader port; replaces the single-cycle memory when fetch latency is modelled.

---
 rtl/imem_fetch_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// Memory end of the instruction-fetch interface: a byte-addressed program store
// answering valid/ready fetch requests after a fixed latency, with flush abort.
module imem_fetch_responder #(
   parameter int WORDLENGTH = 32,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic [WORDLENGTH-1:0] addr,
   input  logic                  flush,
   output logic                  ready,
   output logic                  rvalid,
   output logic [WORDLENGTH-1:0] rdata,
   output logic                  err,
   input  logic                  ld_we,
   input  logic [WORDLENGTH-1:0] ld_addr,
   input  logic [7:0]            ld_data
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic [7:0]            mem [DEPTH];
   logic [AW-3:0]         base;
   logic                  accept;
   logic                  fault;
   logic [WORDLENGTH-1:0] word;
   logic [WORDLENGTH-1:0] word_p0;
   logic                  fault_p0;
   logic                  unused_ld_hi;

   assign accept = req && ready;
   assign base   = addr[AW-1:2];
   assign fault  = (addr[1:0] != 2'b00) || (addr[WORDLENGTH-1:AW] != '0);
   assign word   = WORDLENGTH'({mem[{base, 2'd3}], mem[{base, 2'd2}],
                                mem[{base, 2'd1}], mem[{base, 2'd0}]});

   // Loader addresses wrap modulo DEPTH, so the upper bits carry no meaning.
   assign unused_ld_hi = ^ld_addr[WORDLENGTH-1:AW];

   // Program store is never reset; a same-edge fetch sees the pre-write bytes.
   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr[AW-1:0]] <= ld_data;
   end

   // Stage p0: fetched word and fault flag latched at acceptance.
   always_ff @(posedge clk) begin
      if (accept) begin
         word_p0  <= fault ? '0 : word;
         fault_p0 <= fault;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         ready  <= 1'b1;
         rvalid <= 1'b0;
         rdata  <= '0;
         err    <= 1'b0;
      end else begin
         rvalid <= 1'b0;
         case (state)
            WAIT: begin
               if (flush) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  cnt   <= '0;
               end else if (cnt == 4'd1) begin
                  state  <= RESP;
                  ready  <= 1'b1;
                  rvalid <= 1'b1;
                  rdata  <= word_p0;
                  err    <= fault_p0;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               // IDLE and RESP both accept; a flush here only redirects.
               if (accept) begin
                  if (LATENCY == 1) begin
                     state  <= RESP;
                     ready  <= 1'b1;
                     rvalid <= 1'b1;
                     rdata  <= fault ? '0 : word;
                     err    <= fault;
                  end else begin
                     state <= WAIT;
                     ready <= 1'b0;
                     cnt   <= CNT_INIT;
                  end
               end else begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
